alu_writeback_stage: RTL and testbench

//   Pipeline stage directly downstream of the 16-bit adder ALU. Captures sum D, zero flag Z and carry R

---
 rtl/alu_writeback_stage.sv | 96 +++++++++
 tb/tb_alu_writeback_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// Purpose : ALU writeback stage. It keeps the architectural C/Z flags and buffers results in a 2-entry skid FIFO.
// Latency : 1 cycle from an accepted input to the head on wb_*. Flags become visible the cycle after accept.
// Backpr. : in_ready drops only when both entries are held. It comes from registered state only.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid/in_ready         upstream ALU result handshake
//   in_d, in_z, in_r, in_rd   ALU sum, zero flag, carry-out and destination tag
//   in_wr, in_set_c, in_set_z write-enable (FIFO push) and flag update enables
//   wb_valid/wb_ready         register-file write handshake
//   wb_d, wb_rd               head entry data and tag
//   flag_c, flag_z            architectural flags. flag_c feeds the ALU carry input.
//   wb_count                  completed writebacks. The count wraps.
module alu_writeback_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_d,
    input  logic              in_z,
    input  logic              in_r,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wr,
    input  logic              in_set_c,
    input  logic              in_set_z,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_d,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              flag_c,
    output logic              flag_z,
    output logic [CNT_W-1:0]  wb_count
);

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] rd;
    } entry_t;

    // Slot 0 is always the head. The outputs therefore come straight from a register.
    entry_t     ent [2];
    logic [1:0] occ;

    logic   accept;
    logic   push;
    logic   pop;
    entry_t new_ent;

    assign in_ready = (occ != 2'd2);
    assign wb_valid = (occ != 2'd0);
    assign accept   = in_valid & in_ready;
    assign push     = accept & in_wr;
    assign pop      = wb_valid & wb_ready;
    assign new_ent  = '{d: in_d, rd: in_rd};

    assign wb_d  = ent[0].d;
    assign wb_rd = ent[0].rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            ent[0]   <= '0;
            ent[1]   <= '0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            wb_count <= '0;
        end else begin
            if (accept) begin
                if (in_set_c) flag_c <= in_r;
                if (in_set_z) flag_z <= in_z;
            end
            if (pop) wb_count <= wb_count + 1'b1;

            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) ent[0] <= new_ent;
                    else             ent[1] <= new_ent;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent[0] <= ent[1];
                    occ    <= occ - 2'd1;
                end
                // Push and pop together can only happen at occupancy 1.
                // The incoming entry replaces the departing head.
                2'b11:   ent[0] <= new_ent;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_d;
    logic        in_z;
    logic        in_r;
    logic [2:0]  in_rd;
    logic        in_wr;
    logic        in_set_c;
    logic        in_set_z;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_d;
    logic [2:0]  wb_rd;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] wb_count;

    alu_writeback_stage #(.DATA_W(16), .ADDR_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_d(in_d), .in_z(in_z), .in_r(in_r), .in_rd(in_rd),
        .in_wr(in_wr), .in_set_c(in_set_c), .in_set_z(in_set_z),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_d(wb_d), .wb_rd(wb_rd),
        .flag_c(flag_c), .flag_z(flag_z), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of pending {data, tag} writebacks, plus the flags and the counter.
    logic [18:0] sb_q[$];
    logic        m_fc, m_fz;
    logic [15:0] m_cnt;
    bit          chk_en = 0;
    bit          seen_wrap = 0;
    bit          m_acc, m_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The monitor runs on the falling edge. It first compares the DUT with the model.
    // It then advances the model using the inputs that the next rising edge will see.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(sb_q.size() != 2));
            chk("wb_valid", 32'(wb_valid), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) begin
                chk("wb_d", 32'(wb_d), 32'(sb_q[0][18:3]));
                chk("wb_rd", 32'(wb_rd), 32'(sb_q[0][2:0]));
            end
            chk("flag_c", 32'(flag_c), 32'(m_fc));
            chk("flag_z", 32'(flag_z), 32'(m_fz));
            chk("wb_count", 32'(wb_count), 32'(m_cnt));
        end
        if (rst) begin
            sb_q.delete();
            m_fc   = 1'b0;
            m_fz   = 1'b0;
            m_cnt  = 16'h0;
            chk_en = 1;
        end else if (chk_en) begin
            m_acc = in_valid && (sb_q.size() < 2);
            m_pop = (sb_q.size() > 0) && wb_ready;
            if (m_pop) begin
                void'(sb_q.pop_front());
                m_cnt = m_cnt + 16'h1;
                if (m_cnt == 16'h0) seen_wrap = 1;
            end
            if (m_acc && in_wr) sb_q.push_back({in_d, in_rd});
            if (m_acc && in_set_c) m_fc = in_r;
            if (m_acc && in_set_z) m_fz = in_z;
        end
    end

    // Apply one cycle of stimulus. Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] rd,
                         input logic wr, input logic r, input logic z,
                         input logic sc, input logic sz, input logic rdy);
        in_valid = v;  in_d = d;  in_rd = rd;  in_wr = wr;  in_r = r;  in_z = z;
        in_set_c = sc; in_set_z = sz; wb_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) drive(0, 16'h0, 3'd0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        idle(0, 2);
        rst = 1'b0;
        idle(0, 2);

        // Single writeback with immediate drain.
        drive(1, 16'h1234, 3'd3, 1, 0, 0, 0, 0, 1);
        idle(1, 3);

        // Fill both entries, hold a third request off, then drain in order.
        drive(1, 16'h0001, 3'd1, 1, 0, 0, 0, 0, 0);
        drive(1, 16'h0002, 3'd2, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 16'h0003, 3'd5, 1, 0, 0, 0, 0, 0);
        idle(1, 4);

        // A flag-only op sets C and Z. The next op with set_c=0 leaves C alone.
        drive(1, 16'h0000, 3'd0, 0, 1, 1, 1, 1, 1);
        drive(1, 16'h0000, 3'd0, 0, 0, 0, 0, 0, 1);
        idle(1, 2);

        // Push and pop in the same cycle at occupancy 1.
        drive(1, 16'hAAAA, 3'd6, 1, 0, 0, 0, 0, 0);
        drive(1, 16'h5555, 3'd7, 1, 0, 0, 0, 0, 1);
        idle(0, 2);
        idle(1, 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), 16'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) < 6));
        end
        idle(1, 3);

        // Stream writebacks until the counter sits at 0xFFFF, then pop once more to wrap it.
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            drive(1, 16'($urandom), 3'($urandom), 1, 0, 0, 0, 0, 1);
            guard++;
        end
        chk("stream_budget", 32'(guard < 70000), 32'd1);
        idle(0, 2);
        idle(1, 2);
        chk("wrap_seen", 32'(seen_wrap), 32'd1);

        // A reset while two entries are buffered discards them.
        drive(1, 16'hBEEF, 3'd1, 1, 0, 0, 0, 0, 0);
        drive(1, 16'hCAFE, 3'd2, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(1, 1);
        rst = 1'b0;
        idle(1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
